// File: rtl/alu_seq.sv
// alu_seq: multi-cycle parametrised ALU with start/busy/done handshake.
// Non-shift operations complete in one cycle; variable-distance shifts
// move one bit per cycle through a working register before committing.
module alu_seq #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   ALUOp,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         taken,
  output logic         sc_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ASR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_POS  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_BEQZ = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  state_t         state, state_next;
  logic [W-1:0]   work, work_next;
  logic [SW-1:0]  count, count_next;
  logic           shadow, shadow_next;
  logic           shift_left, shift_left_next;
  logic [W-1:0]   rslt_next;
  logic           taken_next;
  logic           sc_next;

  logic [SW-1:0]  n;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W-1:0]   work_shifted;
  logic           bit_out;
  logic           is_shift;

  assign n        = inB[SW-1:0];
  assign sum      = {1'b0, inA} + {1'b0, inB};
  assign diff     = {1'b0, inA} - {1'b0, inB};
  assign is_shift = (ALUOp == OP_ASR) || (ALUOp == OP_SLL);

  // One-bit step of the working register and the bit that falls off the end.
  assign work_shifted = shift_left ? {work[W-2:0], 1'b0} : {work[W-1], work[W-1:1]};
  assign bit_out      = shift_left ? work[W-1] : work[0];

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath update; visible outputs change only on FINISH entry.
  always_comb begin
    state_next      = state;
    work_next       = work;
    count_next      = count;
    shadow_next     = shadow;
    shift_left_next = shift_left;
    rslt_next       = rslt;
    taken_next      = taken;
    sc_next         = sc_o;

    case (state)
      IDLE: begin
        if (start) begin
          if (is_shift && (n != '0)) begin
            state_next      = SHIFT;
            work_next       = inA;
            count_next      = n;
            shift_left_next = (ALUOp == OP_SLL);
          end else begin
            state_next = FINISH;
            taken_next = 1'b0;
            case (ALUOp)
              OP_LD:          rslt_next = inB;
              OP_ASR, OP_SLL: rslt_next = inA;
              OP_ADD: begin
                rslt_next = sum[W-1:0];
                sc_next   = sum[W];
              end
              OP_POS: begin
                rslt_next  = '0;
                taken_next = ~inA[W-1] & (|inA);
              end
              OP_XOR:         rslt_next = inA ^ inB;
              OP_BEQZ: begin
                rslt_next  = '0;
                taken_next = ~(|inA);
              end
              OP_SUB: begin
                rslt_next = diff[W-1:0];
                sc_next   = ~diff[W];
              end
              default:        rslt_next = rslt;
            endcase
          end
        end
      end

      SHIFT: begin
        work_next   = work_shifted;
        shadow_next = bit_out;
        count_next  = count - CNT_ONE;
        if (count == CNT_ONE) begin
          state_next = FINISH;
          rslt_next  = work_shifted;
          sc_next    = bit_out;
          taken_next = 1'b0;
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and flag registers, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work       <= '0;
      count      <= '0;
      shadow     <= 1'b0;
      shift_left <= 1'b0;
      rslt       <= '0;
      taken      <= 1'b0;
      sc_o       <= 1'b0;
    end else begin
      work       <= work_next;
      count      <= count_next;
      shadow     <= shadow_next;
      shift_left <= shift_left_next;
      rslt       <= rslt_next;
      taken      <= taken_next;
      sc_o       <= sc_next;
    end
  end

endmodule
